// File: rtl/instruction_sequencer_pkg.sv
// Shared decode constants and FSM encoding for the venera_cpu_1 fetch/branch sequencer.
package venera_pkg;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;

  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_JNZ  = 4'hC;
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } seq_state_e;

endpackage

// File: rtl/instruction_sequencer_if.sv
// Fetch/decode side bus of the sequencer: counter strobe, ROM data, counter load and execute port.
interface instruction_sequencer_if #(
  parameter int ADDR_W      = 8,
  parameter int INSTR_W     = 16,
  parameter int STACK_DEPTH = 4
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

  logic               rd;
  logic [ADDR_W-1:0]  address;
  logic [INSTR_W-1:0] instr;
  logic               zero_flag;
  logic               set_valid;
  logic [ADDR_W-1:0]  set_value;
  logic               exec_valid;
  logic [INSTR_W-1:0] exec_instr;
  logic               halted;
  logic               stack_err;
  logic [DEPTH_W-1:0] stack_depth;

  modport master (
    output rd, address, instr, zero_flag,
    input  set_valid, set_value, exec_valid, exec_instr, halted, stack_err, stack_depth
  );

  modport slave (
    input  rd, address, instr, zero_flag,
    output set_valid, set_value, exec_valid, exec_instr, halted, stack_err, stack_depth
  );
endinterface

// File: rtl/instruction_sequencer_return_stack.sv
// Return-address LIFO; the occupancy counter saturates at both ends and never wraps.
module return_stack #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [ADDR_W-1:0]            push_data,
  output logic [ADDR_W-1:0]            top_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(STACK_DEPTH):0] depth
);
  localparam int PTR_W   = $clog2(STACK_DEPTH);
  localparam int DEPTH_W = PTR_W + 1;

  logic [ADDR_W-1:0]  mem_q [STACK_DEPTH];
  logic [ADDR_W-1:0]  mem_d [STACK_DEPTH];
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [PTR_W-1:0]   top_ptr;

  assign full     = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign empty    = (depth_q == '0);
  assign top_ptr  = depth_q[PTR_W-1:0] - PTR_W'(1);
  assign top_data = mem_q[top_ptr];
  assign depth    = depth_q;

  always_comb begin
    mem_d   = mem_q;
    depth_d = depth_q;
    if (push && !full) begin
      mem_d[depth_q[PTR_W-1:0]] = push_data;
      depth_d = depth_q + DEPTH_W'(1);
    end else if (pop && !empty) begin
      depth_d = depth_q - DEPTH_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= '0;
      depth_q <= '0;
    end else begin
      mem_q   <= mem_d;
      depth_q <= depth_d;
    end
  end
endmodule

// File: rtl/instruction_sequencer.sv
// Fetch/branch control: decodes the word fetched one cycle after rd, resolves flow control
// locally and registers counter-load / execute strobes for the following cycle.
module instruction_sequencer
  import venera_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int INSTR_W     = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  instruction_sequencer_if.slave  bus
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

  seq_state_e         state_q, state_d;
  logic               fetch_v_q, fetch_v_d;
  logic               set_valid_q, set_valid_d;
  logic [ADDR_W-1:0]  set_value_q, set_value_d;
  logic               exec_valid_q, exec_valid_d;
  logic [INSTR_W-1:0] exec_instr_q, exec_instr_d;
  logic               halted_q, halted_d;
  logic               stack_err_q, stack_err_d;
  logic [ADDR_W-1:0]  halt_addr_q, halt_addr_d;

  logic               push, pop, full, empty;
  logic [ADDR_W-1:0]  top_data;
  logic [DEPTH_W-1:0] depth;
  logic [3:0]         opcode;
  logic [ADDR_W-1:0]  target, here;

  return_stack #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (bus.address),
    .top_data  (top_data),
    .full      (full),
    .empty     (empty),
    .depth     (depth)
  );

  assign opcode = bus.instr[OPC_HI:OPC_LO];
  assign target = bus.instr[ADDR_W-1:0];
  // The counter already advanced past the fetched word, so the word's own address is one back.
  assign here   = bus.address - ADDR_W'(1);

  always_comb begin
    state_d      = state_q;
    fetch_v_d    = bus.rd;
    set_valid_d  = 1'b0;
    set_value_d  = set_value_q;
    exec_valid_d = 1'b0;
    exec_instr_d = exec_instr_q;
    halted_d     = halted_q;
    stack_err_d  = stack_err_q;
    halt_addr_d  = halt_addr_q;
    push         = 1'b0;
    pop          = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (fetch_v_q) begin
          case (opcode)
            OP_JMP: begin
              set_valid_d = 1'b1;
              set_value_d = target;
            end
            OP_JZ: begin
              if (bus.zero_flag) begin
                set_valid_d = 1'b1;
                set_value_d = target;
              end
            end
            OP_JNZ: begin
              if (!bus.zero_flag) begin
                set_valid_d = 1'b1;
                set_value_d = target;
              end
            end
            OP_CALL: begin
              if (full) begin
                stack_err_d = 1'b1;
                state_d     = ST_HALT;
              end else begin
                push        = 1'b1;
                set_valid_d = 1'b1;
                set_value_d = target;
              end
            end
            OP_RET: begin
              if (empty) begin
                stack_err_d = 1'b1;
                state_d     = ST_HALT;
              end else begin
                pop         = 1'b1;
                set_valid_d = 1'b1;
                set_value_d = top_data;
              end
            end
            OP_HALT: state_d = ST_HALT;
            default: begin
              exec_valid_d = 1'b1;
              exec_instr_d = bus.instr;
            end
          endcase
          if (state_d == ST_HALT) begin
            halted_d    = 1'b1;
            halt_addr_d = here;
            set_valid_d = 1'b1;
            set_value_d = here;
          end
        end
      end
      ST_HALT: begin
        set_valid_d = 1'b1;
        set_value_d = halt_addr_q;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      fetch_v_q    <= 1'b0;
      set_valid_q  <= 1'b0;
      set_value_q  <= '0;
      exec_valid_q <= 1'b0;
      exec_instr_q <= '0;
      halted_q     <= 1'b0;
      stack_err_q  <= 1'b0;
      halt_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      fetch_v_q    <= fetch_v_d;
      set_valid_q  <= set_valid_d;
      set_value_q  <= set_value_d;
      exec_valid_q <= exec_valid_d;
      exec_instr_q <= exec_instr_d;
      halted_q     <= halted_d;
      stack_err_q  <= stack_err_d;
      halt_addr_q  <= halt_addr_d;
    end
  end

  assign bus.set_valid   = set_valid_q;
  assign bus.set_value   = set_value_q;
  assign bus.exec_valid  = exec_valid_q;
  assign bus.exec_instr  = exec_instr_q;
  assign bus.halted      = halted_q;
  assign bus.stack_err   = stack_err_q;
  assign bus.stack_depth = depth;
endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench: emulates the address counter and program ROM around the sequencer and checks every
// cycle against an instruction-level model, plus literal checkpoints from hand-worked timelines.
module tb_instruction_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;

  instruction_sequencer_if #(.ADDR_W(8), .INSTR_W(16), .STACK_DEPTH(4)) bus ();

  instruction_sequencer #(.ADDR_W(8), .INSTR_W(16), .STACK_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] rom [256];
  logic [7:0]  cnt;
  int          phase;
  logic        sv_s, rd_s;
  logic [7:0]  val_s, rd_addr_s;

  // instruction-level model state
  logic [7:0]  stk [$];
  bit          m_halt, prev_rd;
  logic [7:0]  m_halt_addr;
  logic        e_sv, e_ev, e_halted, e_err;
  logic [7:0]  e_val;
  logic [15:0] e_instr;
  int          e_depth;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    stk.delete();
    m_halt = 0; prev_rd = 0; m_halt_addr = 8'h00;
    e_sv = 0; e_ev = 0; e_halted = 0; e_err = 0;
    e_val = 8'h00; e_instr = 16'h0000; e_depth = 0;
  endtask

  task automatic go_halt(input logic [7:0] a, input bit err);
    m_halt = 1; m_halt_addr = a;
    e_sv = 1; e_val = a; e_halted = 1;
    if (err) e_err = 1;
  endtask

  task automatic model_step();
    logic [3:0] op;
    logic [7:0] tgt, here;
    if (reset) begin
      model_reset();
      return;
    end
    e_sv = 0; e_ev = 0;
    if (m_halt) begin
      e_sv = 1; e_val = m_halt_addr;
    end else if (prev_rd) begin
      op   = bus.instr[15:12];
      tgt  = bus.instr[7:0];
      here = bus.address - 8'd1;
      case (op)
        4'hA: begin e_sv = 1; e_val = tgt; end
        4'hB: if (bus.zero_flag)  begin e_sv = 1; e_val = tgt; end
        4'hC: if (!bus.zero_flag) begin e_sv = 1; e_val = tgt; end
        4'hD: if (stk.size() >= 4) go_halt(here, 1);
              else begin stk.push_back(bus.address); e_sv = 1; e_val = tgt; end
        4'hE: if (stk.size() == 0) go_halt(here, 1);
              else begin e_val = stk.pop_back(); e_sv = 1; end
        4'hF: go_halt(here, 0);
        default: begin e_ev = 1; e_instr = bus.instr; end
      endcase
    end
    prev_rd = bus.rd;
    e_depth = stk.size();
  endtask

  task automatic compare_all();
    if (reset) model_reset();
    chk("set_valid",   32'(bus.set_valid),   32'(e_sv));
    chk("set_value",   32'(bus.set_value),   32'(e_val));
    chk("exec_valid",  32'(bus.exec_valid),  32'(e_ev));
    chk("exec_instr",  32'(bus.exec_instr),  32'(e_instr));
    chk("halted",      32'(bus.halted),      32'(e_halted));
    chk("stack_err",   32'(bus.stack_err),   32'(e_err));
    chk("stack_depth", 32'(bus.stack_depth), 32'(e_depth));
  endtask

  // One clock: check at the falling edge, then play the counter/ROM just after the rising edge.
  task automatic tick();
    @(negedge clk);
    compare_all();
    model_step();
    sv_s = bus.set_valid; val_s = bus.set_value;
    rd_s = bus.rd;        rd_addr_s = bus.address;
    @(posedge clk);
    #1;
    if (!reset) begin
      if (sv_s) cnt = val_s;
      else if (rd_s) cnt = cnt + 8'd1;
      bus.instr   = rd_s ? rom[rd_addr_s] : 16'hA0FF;
      phase       = (phase + 1) % 4;
      bus.rd      = (phase == 0);
      bus.address = cnt;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset(input logic [7:0] start, input logic zf);
    reset = 1'b1;
    bus.rd = 1'b0; bus.instr = 16'h0000; bus.address = start; bus.zero_flag = zf;
    ticks(2);
    reset = 1'b0;
    cnt = start; phase = 0;
    bus.rd = 1'b1; bus.address = start;
  endtask

  initial begin
    bus.rd = 1'b0; bus.address = 8'h00; bus.instr = 16'h0000; bus.zero_flag = 1'b0;
    model_reset();

    // EXEC word at 0x00
    clear_rom(); rom[8'h00] = 16'h1234;
    do_reset(8'h00, 1'b0);
    chk("rst_set_valid", 32'(bus.set_valid), 32'd0);
    chk("rst_halted",    32'(bus.halted),    32'd0);
    chk("rst_depth",     32'(bus.stack_depth), 32'd0);
    ticks(2);
    chk("exec_pulse",  32'(bus.exec_valid), 32'd1);
    chk("exec_word",   32'(bus.exec_instr), 32'h1234);
    chk("exec_no_set", 32'(bus.set_valid),  32'd0);
    ticks(1);
    chk("exec_one_cycle", 32'(bus.exec_valid), 32'd0);

    // JMP 0x40 at 0x05
    clear_rom(); rom[8'h05] = 16'hA040;
    do_reset(8'h05, 1'b0);
    ticks(2);
    chk("jmp_set_valid", 32'(bus.set_valid), 32'd1);
    chk("jmp_set_value", 32'(bus.set_value), 32'h40);
    ticks(2);
    chk("jmp_next_rd",   32'(bus.rd),      32'd1);
    chk("jmp_next_addr", 32'(bus.address), 32'h40);
    ticks(4);

    // JZ 0x20 at 0x03, not taken then taken
    clear_rom(); rom[8'h03] = 16'hB020;
    do_reset(8'h03, 1'b0);
    ticks(4);
    chk("jz_nt_addr", 32'(bus.address), 32'h04);
    do_reset(8'h03, 1'b1);
    ticks(4);
    chk("jz_t_addr", 32'(bus.address), 32'h20);

    // CALL 0x80 at 0x10, RET at 0x80
    clear_rom(); rom[8'h10] = 16'hD080; rom[8'h80] = 16'hE000;
    do_reset(8'h10, 1'b0);
    ticks(2);
    chk("call_target", 32'(bus.set_value),   32'h80);
    chk("call_depth",  32'(bus.stack_depth), 32'd1);
    ticks(2);
    chk("call_fetch",  32'(bus.address),     32'h80);
    ticks(2);
    chk("ret_valid",   32'(bus.set_valid),   32'd1);
    chk("ret_value",   32'(bus.set_value),   32'h11);
    chk("ret_depth",   32'(bus.stack_depth), 32'd0);
    ticks(2);
    chk("ret_fetch",   32'(bus.address),     32'h11);

    // five nested CALLs overflow a 4-deep stack
    clear_rom();
    rom[8'h00] = 16'hD010; rom[8'h10] = 16'hD020; rom[8'h20] = 16'hD030;
    rom[8'h30] = 16'hD040; rom[8'h40] = 16'hD050;
    do_reset(8'h00, 1'b0);
    ticks(17);
    chk("ovf_not_yet", 32'(bus.halted), 32'd0);
    ticks(1);
    chk("ovf_halted", 32'(bus.halted),      32'd1);
    chk("ovf_err",    32'(bus.stack_err),   32'd1);
    chk("ovf_pin",    32'(bus.set_value),   32'h40);
    chk("ovf_depth",  32'(bus.stack_depth), 32'd4);
    ticks(6);
    chk("ovf_counter", 32'(bus.address),   32'h40);
    chk("ovf_held",    32'(bus.set_valid), 32'd1);

    // RET on empty stack
    clear_rom(); rom[8'h33] = 16'hE000;
    do_reset(8'h33, 1'b0);
    ticks(2);
    chk("uf_halted", 32'(bus.halted),    32'd1);
    chk("uf_err",    32'(bus.stack_err), 32'd1);
    chk("uf_pin",    32'(bus.set_value), 32'h33);
    ticks(4);

    // HALT at 0x07, then asynchronous reset mid-cycle
    clear_rom(); rom[8'h07] = 16'hF000;
    do_reset(8'h07, 1'b0);
    ticks(1);
    chk("halt_not_yet", 32'(bus.halted), 32'd0);
    ticks(1);
    chk("halt_halted", 32'(bus.halted),    32'd1);
    chk("halt_pin",    32'(bus.set_value), 32'h07);
    chk("halt_sv",     32'(bus.set_valid), 32'd1);
    chk("halt_no_err", 32'(bus.stack_err), 32'd0);
    ticks(5);
    chk("halt_still_pin", 32'(bus.set_value), 32'h07);
    chk("halt_still_sv",  32'(bus.set_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_set_valid",  32'(bus.set_valid),  32'd0);
    chk("arst_set_value",  32'(bus.set_value),  32'd0);
    chk("arst_halted",     32'(bus.halted),     32'd0);
    chk("arst_exec_valid", 32'(bus.exec_valid), 32'd0);

    // mixed program: JNZ not taken, EXEC, JZ taken, CALL at 0xFF wraps, looping to overflow
    clear_rom();
    rom[8'h00] = 16'hC050; rom[8'h01] = 16'h7777; rom[8'h02] = 16'hB060;
    rom[8'h60] = 16'hD0FF; rom[8'hFF] = 16'hD010; rom[8'h10] = 16'hE000;
    do_reset(8'h00, 1'b1);
    ticks(22);
    chk("wrap_ret_sv",    32'(bus.set_valid),   32'd1);
    chk("wrap_ret_value", 32'(bus.set_value),   32'h00);
    chk("wrap_depth",     32'(bus.stack_depth), 32'd1);
    ticks(110);
    chk("mix_end_halted", 32'(bus.halted),    32'd1);
    chk("mix_end_err",    32'(bus.stack_err), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Fetch/branch control for the venera_cpu_1 core. The block sits between the program address counter, the program ROM and the execute unit. It watches the counter's `rd` strobe and captures the fetched instruction word. Flow-control opcodes (JMP, JZ, JNZ, CALL, RET, HALT) are resolved locally and redirect the counter through its `set_valid`/`set_value` load port. All other instructions are forwarded to the execute unit. An internal return-address stack supports one level of call nesting per entry.

## Interface
Parameters:
- `ADDR_W`, 8, program address width (matches counter)
- `INSTR_W`, 16, instruction word width
- `STACK_DEPTH`, 4, return-stack entries (power of 2, ≥2)

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `rd`  in  1  fetch strobe from address counter, 1-cycle pulse every 4 cycles
- `address`  in  ADDR_W  current counter value
- `instr`  in  INSTR_W  ROM data, valid the cycle after `rd`
- `zero_flag`  in  1  ALU zero flag from execute unit
- `set_valid`  out  1  counter load strobe
- `set_value`  out  ADDR_W  counter load value
- `exec_valid`  out  1  1-cycle strobe, `exec_instr` valid
- `exec_instr`  out  INSTR_W  non-flow instruction to execute unit
- `halted`  out  1  core stopped
- `stack_err`  out  1  sticky stack overflow/underflow
- `stack_depth`  out  $clog2(STACK_DEPTH)+1  current stack occupancy

## Operation
- Decode uses `instr[15:12]` as opcode and `instr[ADDR_W-1:0]` as target.
- Opcodes: JMP=4'hA, JZ=4'hB, JNZ=4'hC, CALL=4'hD, RET=4'hE, HALT=4'hF. All others are EXEC.
- FSM states: RUN, HALT.
- RUN: the registered `fetch_v` equals `rd` delayed by 1 cycle. When `fetch_v`=1, `instr` is decoded:
  - JMP → redirect to target.
  - JZ → redirect to target when `zero_flag`=1. Otherwise no action.
  - JNZ → redirect to target when `zero_flag`=0. Otherwise no action.
  - CALL → push `address` (already the fetch address + 1) and redirect to target. If the stack is full, set `stack_err`, push nothing, and go to HALT.
  - RET → pop and redirect to the popped value. If the stack is empty, set `stack_err` and go to HALT.
  - HALT → go to HALT. `halt_addr` = `address` − 1 (mod 2^ADDR_W).
  - EXEC → `exec_valid`=1 and `exec_instr`=`instr` for one cycle.
  - Not-taken branches produce no output.
- `zero_flag` is sampled in the decode cycle only.
- HALT state:
  - `set_valid`=1 every cycle, with `set_value` = `halt_addr` (error halts: the address of the offending instruction). This pins the counter.
  - `halted`=1; `exec_valid`=0.
  - `rd`/`instr` are ignored.
  - Exit is by `reset` only.
- `stack_err` is sticky until reset.
- The stack pointer saturates and never wraps.
- Reset values: state=RUN, `fetch_v`=0, `set_valid`=0, `set_value`=0, `exec_valid`=0, `exec_instr`=0, `halted`=0, `stack_err`=0, `stack_depth`=0.
- Reset asserted mid-operation clears a pending redirect/exec strobe immediately.

## Timing
- Cycle N: `rd`=1. The counter increments at the end of N.
- Cycle N+1: `instr` valid, decode, stack push/pop committed at the end of N+1.
- Cycle N+2: registered outputs:
  - `set_valid`/`exec_valid` pulse high for exactly 1 cycle.
  - The counter loads at the end of N+2.
- Cycle N+4: the next `rd` fetches the redirect target. There is no fetch bubble and no wrong-path fetch.
- HALT:
  - `halted` rises in N+2.
  - `set_valid` is held from N+2 onward.
  - Any `rd` pulses that still occur are ignored.
- `set_value` is held between pulses (last value) while in RUN.
- Target and return address arithmetic is modulo 2^ADDR_W. A CALL at 8'hFF pushes 8'h00.

## Structure
- Package `venera_pkg`:
  - opcode localparams (OP_JMP..OP_HALT)
  - FSM state encoding
  - opcode field bounds
- Sub-module `return_stack`:
  - synchronous LIFO with push, pop, full, empty and depth outputs
  - parameterized by ADDR_W and STACK_DEPTH
  - same `clk`/`reset` semantics
- The top holds the decode, FSM and output registers.

## Test plan
- Reset, then EXEC word 16'h1234 fetched at 8'h00 → `exec_valid` 1 cycle at N+2 with `exec_instr`=16'h1234; no `set_valid`.
- JMP 8'h40 at 8'h05 → `set_valid`=1, `set_value`=8'h40 at N+2; the next `rd` has `address`=8'h40.
- JZ 8'h20 at 8'h03, tested twice:
  - `zero_flag`=0 → no redirect, next fetch at 8'h04.
  - `zero_flag`=1 → redirect to 8'h20.
- CALL 8'h80 at 8'h10, then RET at 8'h80 → push 8'h11, `stack_depth` 1→0, RET redirect `set_value`=8'h11.
- Five nested CALLs with STACK_DEPTH=4 → 5th CALL sets `stack_err`=1 and `halted`=1, and the counter is pinned at the 5th CALL address; RET on an empty stack after reset behaves the same way.
- HALT at 8'h07, then assert `reset` → `halted`=1 from N+2 with `set_value`=8'h07 held every cycle; `reset` clears all outputs asynchronously.
